thermo_scanner: RTL and testbench

THERMO_SCANNER -- requirements
Module: thermo_scanner

---
 rtl/thermo_pkg.sv | 37 +++
 rtl/thermo_timer.sv | 27 ++
 rtl/thermo_scanner.sv | 149 ++++++++++++++
 tb/tb_thermo_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared state codes, converter word field positions and the word decode helper
// for the thermocouple scanner.
package thermo_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_STARTUP = 3'd0;
   localparam state_t ST_REQ     = 3'd1;
   localparam state_t ST_XFER    = 3'd2;
   localparam state_t ST_CAPTURE = 3'd3;
   localparam state_t ST_NEXT    = 3'd4;
   localparam state_t ST_IDLE    = 3'd5;

   localparam int TC_MSB  = 31;
   localparam int TC_LSB  = 18;
   localparam int JT_MSB  = 15;
   localparam int JT_LSB  = 4;
   localparam int FLT_ANY = 16;
   localparam int FLT_SCV = 2;
   localparam int FLT_SCG = 1;
   localparam int FLT_OC  = 0;

   typedef struct packed {
      logic [13:0] tc;
      logic [11:0] jt;
      logic [3:0]  flt;
   } tc_word_t;

   function automatic tc_word_t decode_word(input logic [31:0] w);
      tc_word_t d;
      d.tc  = w[TC_MSB:TC_LSB];
      d.jt  = w[JT_MSB:JT_LSB];
      d.flt = {w[FLT_ANY], w[FLT_SCV], w[FLT_SCG], w[FLT_OC]};
      return d;
   endfunction

endpackage

// File: rtl/thermo_timer.sv
// Loadable down-counter shared by every timed scanner state; done is high
// while the count sits at zero.
module thermo_timer #(
   parameter int            W       = 8,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/thermo_scanner.sv
// Round-robin thermocouple converter scanner driving an external SPI master.
// Define THERMO_STICKY_FAULT_EN to make fault/timeout flags sticky until fault_clr.
//
//   state    | meaning
//   STARTUP  | power-up settle before the first round
//   REQ      | request a transfer on spi_cs_sel
//   XFER     | SPI master busy, wait for completion
//   CAPTURE  | latch decoded word into the channel slot
//   NEXT     | advance channel, wrap into IDLE after the last one
//   IDLE     | poll interval between rounds
module thermo_scanner
   import thermo_pkg::*;
#(
   parameter int CLK_FREQ       = 96000,
   parameter int N_CH           = 4,
   parameter int STARTUP_S      = 3,
   parameter int POLL_CYCLES    = 96000,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       spi_not_busy,
   input  logic [31:0]                                spi_rx_data,
   output logic                                       spi_ena,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] spi_cs_sel,
   input  logic                                       fault_clr,
   output logic [14*N_CH-1:0]                         tc_temp_data,
   output logic [12*N_CH-1:0]                         junction_temp_data,
   output logic [4*N_CH-1:0]                          fault_bits,
   output logic [N_CH-1:0]                            timeout_err,
   output logic                                       sample_stb
);

   localparam int CS_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int STARTUP_CYC = CLK_FREQ * STARTUP_S;
   localparam int MAX_A       = (STARTUP_CYC > POLL_CYCLES) ? STARTUP_CYC : POLL_CYCLES;
   localparam int MAX_CYC     = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int CNT_W       = $clog2(MAX_CYC + 1);

   // Loaded with N-1 so a state lasts exactly N cycles before done is seen.
   localparam logic [CNT_W-1:0] LD_STARTUP = CNT_W'(STARTUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_POLL    = CNT_W'(POLL_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_TMO     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CS_W-1:0]  LAST_CH    = CS_W'(N_CH - 1);

   state_t           state, state_nxt;
   logic             tmr_done, tmr_load, tmo_hit;
   logic [CNT_W-1:0] tmr_val;
   tc_word_t         word;

   assign word = decode_word(spi_rx_data);

   always_comb begin
      state_nxt = state;
      tmo_hit   = 1'b0;
      case (state)
         ST_STARTUP: if (tmr_done) state_nxt = ST_REQ;
         ST_REQ: begin
            if (!spi_not_busy)
               state_nxt = ST_XFER;
            else if (tmr_done) begin
               state_nxt = ST_NEXT;
               tmo_hit   = 1'b1;
            end
         end
         ST_XFER: begin
            if (spi_not_busy)
               state_nxt = ST_CAPTURE;
            else if (tmr_done) begin
               state_nxt = ST_NEXT;
               tmo_hit   = 1'b1;
            end
         end
         ST_CAPTURE: state_nxt = ST_NEXT;
         ST_NEXT:    state_nxt = (spi_cs_sel == LAST_CH) ? ST_IDLE : ST_REQ;
         ST_IDLE:    if (tmr_done) state_nxt = ST_REQ;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tmr_load = (state_nxt != state);
      case (state_nxt)
         ST_STARTUP:      tmr_val = LD_STARTUP;
         ST_IDLE:         tmr_val = LD_POLL;
         ST_REQ, ST_XFER: tmr_val = LD_TMO;
         default:         tmr_val = '0;
      endcase
   end

   thermo_timer #(
      .W       (CNT_W),
      .RST_VAL (LD_STARTUP)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign spi_ena = (state == ST_REQ) && spi_not_busy && !tmr_done;

`ifndef THERMO_STICKY_FAULT_EN
   logic unused_fault_clr;
   assign unused_fault_clr = fault_clr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_STARTUP;
         spi_cs_sel         <= '0;
         sample_stb         <= 1'b0;
         tc_temp_data       <= '0;
         junction_temp_data <= '0;
         fault_bits         <= '0;
         timeout_err        <= '0;
      end else begin
         state      <= state_nxt;
         sample_stb <= (state == ST_CAPTURE);
         if (state == ST_NEXT)
            spi_cs_sel <= (spi_cs_sel == LAST_CH) ? '0 : spi_cs_sel + 1'b1;
`ifdef THERMO_STICKY_FAULT_EN
         if (fault_clr) begin
            fault_bits  <= '0;
            timeout_err <= '0;
         end
`endif
         for (int k = 0; k < N_CH; k++) begin
            if (spi_cs_sel == CS_W'(k)) begin
               if (state == ST_CAPTURE) begin
                  tc_temp_data[14*k +: 14]       <= word.tc;
                  junction_temp_data[12*k +: 12] <= word.jt;
`ifdef THERMO_STICKY_FAULT_EN
                  // A clear in the capture cycle keeps only the new word's bits.
                  fault_bits[4*k +: 4] <= fault_clr ? word.flt : (fault_bits[4*k +: 4] | word.flt);
`else
                  fault_bits[4*k +: 4] <= word.flt;
`endif
                  timeout_err[k] <= 1'b0;
               end
               if (tmo_hit)
                  timeout_err[k] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_thermo_scanner.sv
// Directed bench for thermo_scanner with a small two-channel configuration;
// expectations follow THERMO_STICKY_FAULT_EN when it is defined for the build.
module tb_thermo_scanner;

`ifdef THERMO_STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic        clk          = 1'b0;
   logic        rst          = 1'b1;
   logic        spi_not_busy = 1'b1;
   logic        fault_clr    = 1'b0;
   logic [31:0] spi_rx_data  = '0;
   logic        spi_ena;
   logic        spi_cs_sel;
   logic [27:0] tc_temp_data;
   logic [23:0] junction_temp_data;
   logic [7:0]  fault_bits;
   logic [1:0]  timeout_err;
   logic        sample_stb;

   int n_tests   = 0;
   int n_fail    = 0;
   int stb_count = 0;
   int n;
   int stb_before;

   always #5 clk = ~clk;

   thermo_scanner #(
      .CLK_FREQ       (10),
      .N_CH           (2),
      .STARTUP_S      (1),
      .POLL_CYCLES    (20),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .spi_not_busy       (spi_not_busy),
      .spi_rx_data        (spi_rx_data),
      .spi_ena            (spi_ena),
      .spi_cs_sel         (spi_cs_sel),
      .fault_clr          (fault_clr),
      .tc_temp_data       (tc_temp_data),
      .junction_temp_data (junction_temp_data),
      .fault_bits         (fault_bits),
      .timeout_err        (timeout_err),
      .sample_stb         (sample_stb)
   );

   always @(negedge clk) if (sample_stb) stb_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Counts falling edges until spi_ena is seen high (bounded).
   task automatic wait_ena(output int cyc);
      cyc = 0;
      while (spi_ena !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Called on a falling edge with spi_ena high; returns on the strobe cycle.
   task automatic run_xfer(input logic [31:0] word, input int busy, input logic clr_at_cap);
      spi_not_busy = 1'b0;
      @(negedge clk);
      check("xfer_ena_low", 32'(spi_ena), 32'h0);
      repeat (busy - 1) @(negedge clk);
      spi_rx_data  = word;
      spi_not_busy = 1'b1;
      @(negedge clk);
      fault_clr = clr_at_cap;
      @(negedge clk);
      fault_clr = 1'b0;
      check("capture_stb", 32'(sample_stb), 32'h1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ena", 32'(spi_ena), 32'h0);
      check("rst_cs", 32'(spi_cs_sel), 32'h0);
      check("rst_tc", 32'(tc_temp_data), 32'h0);
      check("rst_jt", 32'(junction_temp_data), 32'h0);
      check("rst_flt", 32'(fault_bits), 32'h0);
      check("rst_tmo", 32'(timeout_err), 32'h0);
      check("rst_stb", 32'(sample_stb), 32'h0);
      rst = 1'b0;

      // Last reset edge enters STARTUP; REQ follows 10 edges later.
      wait_ena(n);
      check("startup_cycles", n, 32'd10);
      check("startup_cs", 32'(spi_cs_sel), 32'h0);

      run_xfer(32'h1234_5678, 8, 1'b0);
      check("ch0_tc", 32'(tc_temp_data[13:0]), 32'h048D);
      check("ch0_jt", 32'(junction_temp_data[11:0]), 32'h567);
      check("ch0_flt", 32'(fault_bits[3:0]), 32'h0);

      wait_ena(n);
      check("ch1_req_lat", n, 32'd1);
      check("ch1_cs", 32'(spi_cs_sel), 32'h1);
      check("stb_single", 32'(sample_stb), 32'h0);

      run_xfer(32'h0001_0007, 5, 1'b0);
      check("ch1_flt", 32'(fault_bits[7:4]), 32'hF);
      check("ch1_tc", 32'(tc_temp_data[27:14]), 32'h0);
      check("ch0_keep", 32'(tc_temp_data[13:0]), 32'h048D);

      // NEXT -> IDLE on the first edge, then 20 IDLE cycles.
      wait_ena(n);
      check("idle_cycles", n, 32'd21);
      check("wrap_cs", 32'(spi_cs_sel), 32'h0);

      // ch0 never completes: 1 edge into XFER + 50 dwell cycles.
      stb_before   = stb_count;
      spi_not_busy = 1'b0;
      n = 0;
      while (timeout_err == 2'b00 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", n, 32'd51);
      check("tmo_flags", 32'(timeout_err), 32'h1);
      check("tmo_no_stb", stb_count, stb_before);
      check("tmo_keep_tc", 32'(tc_temp_data[13:0]), 32'h048D);
      spi_not_busy = 1'b1;
      wait_ena(n);
      check("tmo_next_lat", n, 32'd1);
      check("tmo_next_cs", 32'(spi_cs_sel), 32'h1);

      run_xfer(32'h4000_0010, 3, 1'b0);
      check("ch1_tc2", 32'(tc_temp_data[27:14]), 32'h1000);
      check("ch1_jt2", 32'(junction_temp_data[23:12]), 32'h001);
      check("ch1_flt2", 32'(fault_bits[7:4]), STICKY ? 32'hF : 32'h0);
      check("tmo_hold", 32'(timeout_err), 32'h1);

      wait_ena(n);
      check("idle_cycles2", n, 32'd21);
      run_xfer(32'h0000_0002, 2, 1'b0);
      check("ch0_flt3", 32'(fault_bits[3:0]), 32'h2);
      check("tmo_cleared", 32'(timeout_err), 32'h0);

      wait_ena(n);
      run_xfer(32'h0000_0004, 2, 1'b0);
      check("ch1_flt3", 32'(fault_bits[7:4]), STICKY ? 32'hF : 32'h4);

      wait_ena(n);
      check("idle_cycles3", n, 32'd21);
      run_xfer(32'h0000_0000, 2, 1'b0);
      check("clean_word", 32'(fault_bits), STICKY ? 32'hF2 : 32'h40);

      wait_ena(n);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("clr_pulse", 32'(fault_bits), STICKY ? 32'h00 : 32'h40);
      check("clr_still_req", 32'(spi_ena), 32'h1);
      run_xfer(32'h0000_0001, 2, 1'b1);
      check("clr_with_cap", 32'(fault_bits), 32'h10);

      // Reset in the middle of a ch0 transfer.
      wait_ena(n);
      check("idle_cycles4", n, 32'd21);
      spi_not_busy = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("xrst_ena", 32'(spi_ena), 32'h0);
      check("xrst_cs", 32'(spi_cs_sel), 32'h0);
      check("xrst_data", 32'(tc_temp_data) | 32'(junction_temp_data), 32'h0);
      check("xrst_flags", {22'h0, fault_bits, timeout_err}, 32'h0);
      check("xrst_stb", 32'(sample_stb), 32'h0);
      spi_rx_data  = 32'h0001_0007;
      spi_not_busy = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_ena(n);
      check("xrst_startup", n, 32'd10);
      check("xrst_no_cap", 32'(fault_bits), 32'h0);
      check("stb_total", stb_count, 32'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
